// File: rtl/vlsu_txn_arbiter.sv
// Round-robin arbiter sharing one AXI address-issue slot between vector loads (AR) and stores (AW).
// Tracks in-flight bursts per direction and never lets loads and stores overlap on the bus.
module vlsu_txn_arbiter #(
    parameter int unsigned ReqWidth       = 64,
    parameter int unsigned MaxOutstanding = 8,
    parameter int unsigned CntWidth       = $clog2(MaxOutstanding + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [ReqWidth-1:0] ld_req_i,
    input  logic                ld_valid_i,
    output logic                ld_ready_o,
    input  logic [ReqWidth-1:0] st_req_i,
    input  logic                st_valid_i,
    output logic                st_ready_o,
    output logic [ReqWidth-1:0] req_o,
    output logic                req_is_store_o,
    output logic                req_valid_o,
    input  logic                req_ready_i,
    input  logic                r_last_hs_i,
    input  logic                b_hs_i,
    input  logic                fence_i,
    output logic                idle_o,
    output logic [CntWidth-1:0] ld_outstanding_o,
    output logic [CntWidth-1:0] st_outstanding_o
);

    typedef enum logic {StLoad, StStore} dir_e;

    localparam logic [CntWidth:0] MaxCnt = MaxOutstanding[CntWidth:0];

    dir_e                dir_q, dir_d;
    logic                prefer_st_q, prefer_st_d;
    logic                slot_valid_q, slot_valid_d;
    logic                slot_store_q, slot_store_d;
    logic [ReqWidth-1:0] slot_req_q, slot_req_d;
    logic [CntWidth-1:0] ld_cnt_q, ld_cnt_d;
    logic [CntWidth-1:0] st_cnt_q, st_cnt_d;

    logic                slot_ld, slot_st, slot_free;
    logic [CntWidth:0]   ld_inflight, st_inflight;
    logic                ld_base, st_base, ld_elig, st_elig;
    logic                gnt_ld, gnt_st;
    logic                ld_inc, ld_dec, st_inc, st_dec;

    assign slot_ld     = slot_valid_q && !slot_store_q;
    assign slot_st     = slot_valid_q && slot_store_q;
    assign slot_free   = !slot_valid_q || req_ready_i;
    assign ld_inflight = {1'b0, ld_cnt_q} + {{CntWidth{1'b0}}, slot_ld};
    assign st_inflight = {1'b0, st_cnt_q} + {{CntWidth{1'b0}}, slot_st};

    // A direction may only take the bus once the opposite direction has fully drained.
    assign ld_base = ld_valid_i && !fence_i && (ld_inflight < MaxCnt)
                     && (dir_q == StLoad || (st_cnt_q == '0 && !slot_st));
    assign st_base = st_valid_i && !fence_i && (st_inflight < MaxCnt)
                     && (dir_q == StStore || (ld_cnt_q == '0 && !slot_ld));

    // Drain mode: stop feeding the current direction while the other side waits its turn.
    assign ld_elig = ld_base && !(dir_q == StLoad && st_valid_i && prefer_st_q);
    assign st_elig = st_base && !(dir_q == StStore && ld_valid_i && !prefer_st_q);

    assign gnt_ld = rst_ni && slot_free && ld_elig && (!st_elig || !prefer_st_q);
    assign gnt_st = rst_ni && slot_free && st_elig && (!ld_elig || prefer_st_q);

    assign ld_ready_o       = gnt_ld;
    assign st_ready_o       = gnt_st;
    assign req_o            = slot_req_q;
    assign req_is_store_o   = slot_store_q;
    assign req_valid_o      = slot_valid_q;
    assign ld_outstanding_o = ld_cnt_q;
    assign st_outstanding_o = st_cnt_q;
    assign idle_o           = !slot_valid_q && (ld_cnt_q == '0) && (st_cnt_q == '0);

    always_comb begin
        dir_d        = dir_q;
        prefer_st_d  = prefer_st_q;
        slot_valid_d = slot_valid_q;
        slot_store_d = slot_store_q;
        slot_req_d   = slot_req_q;
        if (gnt_ld || gnt_st) begin
            slot_valid_d = 1'b1;
            slot_store_d = gnt_st;
            slot_req_d   = gnt_st ? st_req_i : ld_req_i;
            prefer_st_d  = gnt_ld;
        end else if (req_ready_i) begin
            slot_valid_d = 1'b0;
        end
        case (dir_q)
            StLoad:  if (gnt_st) dir_d = StStore;
            StStore: if (gnt_ld) dir_d = StLoad;
            default: dir_d = StLoad;
        endcase
    end

    assign ld_inc = slot_valid_q && req_ready_i && !slot_store_q;
    assign st_inc = slot_valid_q && req_ready_i && slot_store_q;
    // Completions at zero are stale (e.g. from before a reset) and are dropped.
    assign ld_dec = r_last_hs_i && (ld_cnt_q != '0);
    assign st_dec = b_hs_i && (st_cnt_q != '0);

    always_comb begin
        ld_cnt_d = ld_cnt_q;
        st_cnt_d = st_cnt_q;
        if (ld_inc && !ld_dec) ld_cnt_d = ld_cnt_q + 1'b1;
        if (!ld_inc && ld_dec) ld_cnt_d = ld_cnt_q - 1'b1;
        if (st_inc && !st_dec) st_cnt_d = st_cnt_q + 1'b1;
        if (!st_inc && st_dec) st_cnt_d = st_cnt_q - 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dir_q        <= StLoad;
            prefer_st_q  <= 1'b0;
            slot_valid_q <= 1'b0;
            slot_store_q <= 1'b0;
            slot_req_q   <= '0;
            ld_cnt_q     <= '0;
            st_cnt_q     <= '0;
        end else begin
            dir_q        <= dir_d;
            prefer_st_q  <= prefer_st_d;
            slot_valid_q <= slot_valid_d;
            slot_store_q <= slot_store_d;
            slot_req_q   <= slot_req_d;
            ld_cnt_q     <= ld_cnt_d;
            st_cnt_q     <= st_cnt_d;
        end
    end

    a_ld_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        r_last_hs_i |-> ld_cnt_q != '0)
        else $warning("load completion with no outstanding load burst ignored");
    a_st_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        b_hs_i |-> st_cnt_q != '0)
        else $warning("store completion with no outstanding store burst ignored");
    a_ld_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        ld_inc |-> {1'b0, ld_cnt_q} < MaxCnt);
    a_st_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        st_inc |-> {1'b0, st_cnt_q} < MaxCnt);
    a_no_mixed: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(ld_cnt_q != '0 && st_cnt_q != '0));
    a_req_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        req_valid_o && !req_ready_i |=> req_valid_o && $stable(req_o) && $stable(req_is_store_o));

endmodule

// File: tb/tb_vlsu_txn_arbiter.sv
// Bench for vlsu_txn_arbiter: per-cycle vector table plus a scoreboard of granted payloads.
module tb_vlsu_txn_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [63:0] ld_req_i, st_req_i, req_o;
    logic        ld_valid_i, st_valid_i, ld_ready_o, st_ready_o;
    logic        req_is_store_o, req_valid_o, req_ready_i;
    logic        r_last_hs_i, b_hs_i, fence_i, idle_o;
    logic [3:0]  ld_outstanding_o, st_outstanding_o;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic lv, sv, fe, rdy, rl, bh;
        logic lr, sr, val, st;
        logic [3:0] lo, so;
        logic idl;
    } vec_t;

    typedef struct packed {
        logic [63:0] req;
        logic        st;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb_q[$];

    vlsu_txn_arbiter dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .ld_req_i         (ld_req_i),
        .ld_valid_i       (ld_valid_i),
        .ld_ready_o       (ld_ready_o),
        .st_req_i         (st_req_i),
        .st_valid_i       (st_valid_i),
        .st_ready_o       (st_ready_o),
        .req_o            (req_o),
        .req_is_store_o   (req_is_store_o),
        .req_valid_o      (req_valid_o),
        .req_ready_i      (req_ready_i),
        .r_last_hs_i      (r_last_hs_i),
        .b_hs_i           (b_hs_i),
        .fence_i          (fence_i),
        .idle_o           (idle_o),
        .ld_outstanding_o (ld_outstanding_o),
        .st_outstanding_o (st_outstanding_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic lv, sv, fe, rdy, rl, bh, lr, sr, val, st,
                       input int lo, so, input logic idl);
        vecs.push_back('{lv, sv, fe, rdy, rl, bh, lr, sr, val, st, 4'(lo), 4'(so), idl});
    endtask

    // Scoreboard: every grant queues its payload; the slot must present the oldest one.
    always @(negedge clk_i) begin
        if (!rst_ni) begin
            sb_q.delete();
        end else begin
            if (req_valid_o) begin
                check("sb occupancy", 64'(sb_q.size() != 0), 64'd1);
                if (sb_q.size() != 0) begin
                    check("sb req_o", req_o, sb_q[0].req);
                    check("sb is_store", 64'(req_is_store_o), 64'(sb_q[0].st));
                    if (req_ready_i) void'(sb_q.pop_front());
                end
            end
            if (ld_valid_i && ld_ready_o) sb_q.push_back('{ld_req_i, 1'b0});
            if (st_valid_i && st_ready_o) sb_q.push_back('{st_req_i, 1'b1});
            check("ready exclusive", 64'(ld_ready_o && st_ready_o), 64'd0);
            check("no mixed traffic",
                  64'(ld_outstanding_o != 0 && st_outstanding_o != 0), 64'd0);
        end
    end

    task automatic drive(input vec_t v);
        ld_valid_i  = v.lv;
        st_valid_i  = v.sv;
        fence_i     = v.fe;
        req_ready_i = v.rdy;
        r_last_hs_i = v.rl;
        b_hs_i      = v.bh;
        ld_req_i    = {$urandom, $urandom};
        st_req_i    = {$urandom, $urandom};
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " req_valid"}, 64'(req_valid_o), 64'd0);
        check({tag, " req_o"}, req_o, 64'd0);
        check({tag, " is_store"}, 64'(req_is_store_o), 64'd0);
        check({tag, " ld_ready"}, 64'(ld_ready_o), 64'd0);
        check({tag, " st_ready"}, 64'(st_ready_o), 64'd0);
        check({tag, " ld_out"}, 64'(ld_outstanding_o), 64'd0);
        check({tag, " st_out"}, 64'(st_outstanding_o), 64'd0);
        check({tag, " idle"}, 64'(idle_o), 64'd1);
    endtask

    initial begin
        vec_t v;
        rst_ni = 1'b0;
        v = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'd0, 4'd0, 0};
        drive(v);
        ld_req_i = '0;
        st_req_i = '0;

        // Loads only: cap of 8, then one completion frees a slot.
        add(1,0,0,1,0,0, 1,0,0,0, 0,0,1);
        add(1,0,0,1,0,0, 1,0,1,0, 0,0,0);
        for (int k = 2; k <= 7; k++) add(1,0,0,1,0,0, 1,0,1,0, k-1,0,0);
        add(1,0,0,1,0,0, 0,0,1,0, 7,0,0);
        add(1,0,0,1,0,0, 0,0,0,0, 8,0,0);
        add(1,0,0,1,1,0, 0,0,0,0, 8,0,0);
        add(1,0,0,1,0,0, 1,0,0,0, 7,0,0);
        add(0,0,0,1,0,0, 0,0,1,0, 7,0,0);
        for (int i = 0; i < 5; i++) add(0,0,0,1,1,0, 0,0,0,0, 8-i,0,0);
        // Direction switch: store waits for three load completions; loads held off meanwhile.
        add(0,1,0,1,0,0, 0,0,0,0, 3,0,0);
        add(1,1,0,1,1,0, 0,0,0,0, 3,0,0);
        add(1,1,0,1,1,0, 0,0,0,0, 2,0,0);
        add(1,1,0,1,1,0, 0,0,0,0, 1,0,0);
        add(1,1,0,1,0,0, 0,1,0,0, 0,0,1);
        add(1,0,0,1,0,0, 0,0,1,1, 0,0,0);
        add(1,0,0,1,0,1, 0,0,0,0, 0,1,0);
        add(1,0,0,1,0,0, 1,0,0,0, 0,0,1);
        add(0,0,0,1,0,0, 0,0,1,0, 0,0,0);
        add(0,0,0,1,1,0, 0,0,0,0, 1,0,0);
        add(0,0,0,1,0,0, 0,0,0,0, 0,0,1);
        // Both valid: S, drain, L, drain, S.
        add(1,1,0,1,0,0, 0,1,0,0, 0,0,1);
        add(1,1,0,1,0,0, 0,0,1,1, 0,0,0);
        add(1,1,0,1,0,0, 0,0,0,0, 0,1,0);
        add(1,1,0,1,0,1, 0,0,0,0, 0,1,0);
        add(1,1,0,1,0,0, 1,0,0,0, 0,0,1);
        add(1,1,0,1,0,0, 0,0,1,0, 0,0,0);
        add(1,1,0,1,1,0, 0,0,0,0, 1,0,0);
        add(1,1,0,1,0,0, 0,1,0,0, 0,0,1);
        add(0,0,0,1,0,0, 0,0,1,1, 0,0,0);
        add(0,0,0,1,0,1, 0,0,0,0, 0,1,0);
        add(0,0,0,1,0,0, 0,0,0,0, 0,0,1);
        // Backpressure: five stalled cycles, then release.
        add(0,1,0,0,0,0, 0,1,0,0, 0,0,1);
        for (int i = 0; i < 5; i++) add(0,1,0,0,0,0, 0,0,1,1, 0,0,0);
        add(0,0,0,1,0,0, 0,0,1,1, 0,0,0);
        // Accept and completion in the same cycle, then a spurious completion at zero.
        add(0,1,0,1,0,0, 0,1,0,0, 0,1,0);
        add(0,1,0,1,0,0, 0,1,1,1, 0,1,0);
        add(0,0,0,1,0,1, 0,0,1,1, 0,2,0);
        add(0,0,0,1,0,0, 0,0,0,0, 0,2,0);
        add(0,0,0,1,0,1, 0,0,0,0, 0,2,0);
        add(0,0,0,1,0,1, 0,0,0,0, 0,1,0);
        add(0,0,0,1,0,1, 0,0,0,0, 0,0,1);
        add(0,0,0,1,0,0, 0,0,0,0, 0,0,1);
        // Fence with two loads out and one in the slot.
        add(1,0,0,1,0,0, 1,0,0,0, 0,0,1);
        add(1,0,0,1,0,0, 1,0,1,0, 0,0,0);
        add(1,0,0,1,0,0, 1,0,1,0, 1,0,0);
        add(1,0,1,0,0,0, 0,0,1,0, 2,0,0);
        add(1,0,1,1,0,0, 0,0,1,0, 2,0,0);
        add(1,0,1,1,0,0, 0,0,0,0, 3,0,0);
        add(1,0,1,1,1,0, 0,0,0,0, 3,0,0);
        add(1,0,1,1,1,0, 0,0,0,0, 2,0,0);
        add(1,0,1,1,1,0, 0,0,0,0, 1,0,0);
        add(1,0,1,1,0,0, 0,0,0,0, 0,0,1);

        repeat (2) @(posedge clk_i);
        #1;
        check_reset_outputs("reset");
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            drive(v);
            @(negedge clk_i);
            check($sformatf("row%0d ld_ready", i), 64'(ld_ready_o), 64'(v.lr));
            check($sformatf("row%0d st_ready", i), 64'(st_ready_o), 64'(v.sr));
            check($sformatf("row%0d req_valid", i), 64'(req_valid_o), 64'(v.val));
            if (v.val) check($sformatf("row%0d is_store", i), 64'(req_is_store_o), 64'(v.st));
            check($sformatf("row%0d ld_out", i), 64'(ld_outstanding_o), 64'(v.lo));
            check($sformatf("row%0d st_out", i), 64'(st_outstanding_o), 64'(v.so));
            check($sformatf("row%0d idle", i), 64'(idle_o), 64'(v.idl));
            @(posedge clk_i);
            #1;
        end

        // Reset in the middle of a load burst: one load accepted, another sitting in the slot.
        v = '{1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 4'd0, 4'd0, 0};
        drive(v);
        @(posedge clk_i);
        #1;
        ld_req_i = 64'h0123_4567_89ab_cdef;
        @(posedge clk_i);
        #1;
        check("mid-burst ld_out", 64'(ld_outstanding_o), 64'd1);
        check("mid-burst slot", req_o, 64'h0123_4567_89ab_cdef);
        #1;
        rst_ni = 1'b0;
        #1;
        check_reset_outputs("async reset");
        @(negedge clk_i);
        ld_valid_i = 1'b0;
        rst_ni     = 1'b1;
        @(posedge clk_i);
        #1;
        r_last_hs_i = 1'b1;
        @(posedge clk_i);
        #1;
        r_last_hs_i = 1'b0;
        check("stale completion ld_out", 64'(ld_outstanding_o), 64'd0);
        ld_valid_i = 1'b1;
        @(negedge clk_i);
        check("grant after reset", 64'(ld_ready_o), 64'd1);
        @(posedge clk_i);
        #1;
        ld_valid_i = 1'b0;
        check("post-reset req_valid", 64'(req_valid_o), 64'd1);
        repeat (2) @(posedge clk_i);
        #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vlsu_txn_arbiter.md
Name: vlsu_txn_arbiter

Overview:
- Shares the single AXI address-issue slot between the vector load path (AR) and the vector store path (AW).
- Arbitrates load and store burst requests round-robin and counts outstanding bursts per direction against a cap.
- On a direction switch, holds the new direction until the opposite direction has drained, so loads and stores are never in flight at the same time.
- Provides a fence/idle handshake so the dispatcher can wait for all vector memory traffic to complete.

Parameters:
- ReqWidth, 64, bit width of the opaque burst request payload (address, len, size, burst).
- MaxOutstanding, 8, maximum in-flight bursts per direction; must be ≥1.
- CntWidth, $clog2(MaxOutstanding+1), width of the outstanding counters (derived; do not override).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- ld_req_i  in  ReqWidth  load burst request
- ld_valid_i  in  1  load request valid
- ld_ready_o  out  1  load request accepted
- st_req_i  in  ReqWidth  store burst request
- st_valid_i  in  1  store request valid
- st_ready_o  out  1  store request accepted
- req_o  out  ReqWidth  granted request toward AXI AR/AW issue
- req_is_store_o  out  1  1 = AW, 0 = AR
- req_valid_o  out  1  output slot full
- req_ready_i  in  1  downstream accepts req_o
- r_last_hs_i  in  1  pulse: R beat with last=1 handshaken (one load burst done)
- b_hs_i  in  1  pulse: B response handshaken (one store burst done)
- fence_i  in  1  level: block new grants
- idle_o  out  1  no slot occupancy, both counters zero
- ld_outstanding_o  out  CntWidth  in-flight load bursts
- st_outstanding_o  out  CntWidth  in-flight store bursts

Behaviour:
- Reset values:
  - req_valid_o=0, req_o=0, req_is_store_o=0.
  - ld_ready_o=st_ready_o=0.
  - Counters=0, idle_o=1.
  - RR pointer = "load preferred"; direction register cur_dir=LOAD.
- Output slot is a single register stage. Slot is free when req_valid_o=0, or when req_valid_o && req_ready_i (same-cycle refill allowed).
- Input eligibility:
  - Load eligible: ld_valid_i && !fence_i && (ld_outstanding_o + slot_holds_load) < MaxOutstanding && (cur_dir==LOAD || (st_outstanding_o==0 && !slot_holds_store)).
  - Store eligible: the symmetric condition.
- Grant:
  - If the slot is free and at least one input is eligible, grant exactly one.
  - If both are eligible, grant the side not granted last (RR). The RR pointer flips after each grant.
  - ld_ready_o/st_ready_o are asserted combinationally in the grant cycle only. The payload is latched into req_o next edge with req_is_store_o set accordingly, and cur_dir is updated to the granted direction.
- FSM on cur_dir, states LOAD and STORE:
  - LOAD→STORE only when the store side is granted, which requires st eligibility, i.e. loads drained (ld_outstanding_o==0 and no load in slot).
  - The reverse transition is symmetric.
  - A pending request of the other direction does not block same-direction grants beyond RR fairness: while draining, the current direction is still granted. RR starvation is prevented by suppressing current-direction grants while the other side is valid and the RR pointer favours it ("drain mode").
- Counters:
  - ld counter +1 on req_valid_o && req_ready_i && !req_is_store_o; −1 on r_last_hs_i. Store counter is the same with b_hs_i.
  - Simultaneous +1/−1 in the same cycle: value unchanged.
  - −1 at zero: ignored, counter stays 0; flagged by assertion.
  - +1 at MaxOutstanding is impossible by construction; covered by assertion.
- Fence:
  - fence_i blocks new grants only. A request already in the slot is still presented and may complete.
  - idle_o = !req_valid_o && counters==0, registered-free (combinational from state).
- req_o holds stable while req_valid_o && !req_ready_i (AXI stability); assertion.
- Reset mid-operation: all state is cleared asynchronously; in-flight completions after reset are ignored by the underflow rule.
- Latency: grant → req_valid_o is 1 cycle; back-to-back throughput is 1 request/cycle in the same direction with req_ready_i=1.

Test Plan:
- Loads only: 10 loads with req_ready_i=1 and MaxOutstanding=8, no completions → 8 granted, ld_outstanding_o=8, ld_ready_o stays 0. One r_last_hs_i pulse → 9th load granted next cycle.
- Direction switch: 3 loads outstanding, then store valid → st_ready_o=0 until 3 r_last_hs_i pulses. The store is granted in the cycle ld_outstanding_o=0 and appears as req_is_store_o=1 one cycle later.
- Both valid with direction drained (counters 0): alternate grants L,S only after each drains. Check no simultaneous ld_outstanding_o>0 && st_outstanding_o>0.
- Backpressure: req_ready_i=0 for 5 cycles → req_o/req_is_store_o stable, no new ready. Release → handshake, counter +1.
- Same-cycle accept plus completion: st_outstanding_o=2, downstream accept of a store with b_hs_i in the same cycle → stays 2. Spurious b_hs_i at 0 → stays 0, assertion fires.
- Fence and reset: fence_i=1 with 2 loads out and 1 in slot → slot drains, no grants. After 3 r_last_hs_i, idle_o=1. Assert rst_ni low mid-burst → all outputs return to reset values immediately.
